// File: rtl/pointer_register.sv
// pointer_register: 16-bit CPU pointer with byte-wise load/readback, increment and tri-state buses.
// Define POINTER_REG_CARRY_EN to add the combinational ripple-carry output co.
module pointer_register #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  di,
  input  logic        n_oe_addr,
  input  logic        n_oe_dl,
  input  logic        n_oe_dh,
  input  logic        cnt,
  input  logic        n_we_l,
  input  logic        n_we_h,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out
`ifdef POINTER_REG_CARRY_EN
  ,
  output logic        co
`endif
);

  logic [15:0] r_ptr;
  logic [15:0] w_ptr_next;
  logic        w_write;

  assign w_write = ~n_we_l | ~n_we_h;

  // Next pointer: reset beats a byte write, and a byte write suppresses counting.
  always_comb begin
    w_ptr_next = r_ptr;
    if (rst) begin
      w_ptr_next = RESET_VALUE;
    end else if (w_write) begin
      if (!n_we_l) begin
        w_ptr_next[7:0] = di;
      end else begin
        w_ptr_next[7:0] = r_ptr[7:0];
      end
      if (!n_we_h) begin
        w_ptr_next[15:8] = di;
      end else begin
        w_ptr_next[15:8] = r_ptr[15:8];
      end
    end else if (cnt) begin
      w_ptr_next = r_ptr + 16'd1;
    end else begin
      w_ptr_next = r_ptr;
    end
  end

  // Pointer state register.
  always_ff @(posedge clk) begin
    r_ptr <= w_ptr_next;
  end

  assign addr_out = n_oe_addr ? 16'hzzzz : r_ptr;

  // Low byte has precedence when both data enables are active.
  assign data_out = (!n_oe_dl) ? r_ptr[7:0] :
                    (!n_oe_dh) ? r_ptr[15:8] : 8'hzz;

`ifdef POINTER_REG_CARRY_EN
  assign co = cnt & (r_ptr == 16'hFFFF) & ~rst & n_we_l & n_we_h;
`endif

endmodule

// File: tb/tb_pointer_register.sv
// tb_pointer_register: two pointer_register instances sharing address/data buses, scoreboard-checked.
// The bench can also drive the shared buses itself to show that disabled instances release them.
module tb_pointer_register;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  di;
  logic [1:0]  n_oe_addr, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h;
  wire  [15:0] addr_bus;
  wire  [7:0]  data_bus;
  logic        tb_en;
  logic [15:0] tb_addr;
  logic [7:0]  tb_data;
`ifdef POINTER_REG_CARRY_EN
  wire  [1:0]  co_w;
`endif

  logic [15:0] m [2];
  logic [15:0] exp_q [$];
  string       tag_q [$];
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  assign addr_bus = tb_en ? tb_addr : 16'hzzzz;
  assign data_bus = tb_en ? tb_data : 8'hzz;

  pointer_register #(.RESET_VALUE(RV)) u_a (
    .clk(clk), .rst(rst), .di(di),
    .n_oe_addr(n_oe_addr[0]), .n_oe_dl(n_oe_dl[0]), .n_oe_dh(n_oe_dh[0]),
    .cnt(cnt[0]), .n_we_l(n_we_l[0]), .n_we_h(n_we_h[0]),
    .addr_out(addr_bus), .data_out(data_bus)
`ifdef POINTER_REG_CARRY_EN
    , .co(co_w[0])
`endif
  );

  pointer_register #(.RESET_VALUE(RV)) u_b (
    .clk(clk), .rst(rst), .di(di),
    .n_oe_addr(n_oe_addr[1]), .n_oe_dl(n_oe_dl[1]), .n_oe_dh(n_oe_dh[1]),
    .cnt(cnt[1]), .n_we_l(n_we_l[1]), .n_we_h(n_we_h[1]),
    .addr_out(addr_bus), .data_out(data_bus)
`ifdef POINTER_REG_CARRY_EN
    , .co(co_w[1])
`endif
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Only instance s drives the address bus; data bus released.
  task automatic sel_addr(input int s);
    n_oe_addr = (s == 0) ? 2'b10 : 2'b01;
    n_oe_dl   = 2'b11;
    n_oe_dh   = 2'b11;
    #1;
  endtask

  // Read a byte of instance s onto the data bus with the given enables.
  task automatic rd(input int s, input string tag, input logic dl, input logic dh, input logic [7:0] exp);
    n_oe_addr = 2'b11;
    n_oe_dl   = 2'b11;
    n_oe_dh   = 2'b11;
    n_oe_dl[s] = dl;
    n_oe_dh[s] = dh;
    #1;
    chk(tag, {8'h00, data_bus}, {8'h00, exp});
  endtask

  // One clock on instance s: drive, predict, push, clock, pop and compare.
  task automatic cyc(input int s, input string tag, input logic r, input logic c,
                     input logic wl, input logic wh, input logic [7:0] d, input bit rb);
    logic [15:0] nx;
    rst = r; di = d; cnt[s] = c; n_we_l[s] = wl; n_we_h[s] = wh;
    #1;
`ifdef POINTER_REG_CARRY_EN
    chk({tag, "_co"}, {15'h0000, co_w[s]},
        {15'h0000, c & (m[s] == 16'hFFFF) & ~r & wl & wh});
`endif
    if (rb) begin
      rd(s, {tag, "_old"}, 1'b0, 1'b1, m[s][7:0]);
    end
    nx = m[s];
    if (!wl || !wh) begin
      if (!wl) nx[7:0]  = d;
      if (!wh) nx[15:8] = d;
    end else if (c) begin
      nx = nx + 16'd1;
    end
    if (r) begin
      m[0] = RV;
      m[1] = RV;
    end else begin
      m[s] = nx;
    end
    exp_q.push_back(m[s]);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    rst = 1'b0; cnt = 2'b00; n_we_l = 2'b11; n_we_h = 2'b11; di = 8'h00;
    sel_addr(s);
    chk(tag_q.pop_front(), addr_bus, exp_q.pop_front());
  endtask

  task automatic load(input int s, input logic [15:0] v);
    cyc(s, "ld_l", 1'b0, 1'b0, 1'b0, 1'b1, v[7:0], 1'b0);
    cyc(s, "ld_h", 1'b0, 1'b0, 1'b1, 1'b0, v[15:8], 1'b0);
  endtask

  initial begin
    rst = 1'b0; di = 8'h00; cnt = 2'b00; n_we_l = 2'b11; n_we_h = 2'b11;
    n_oe_addr = 2'b10; n_oe_dl = 2'b11; n_oe_dh = 2'b11;
    tb_en = 1'b0; tb_addr = 16'h0000; tb_data = 8'h00;
    m[0] = 16'h0000; m[1] = 16'h0000;
    #2;

    cyc(0, "reset_a", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    sel_addr(1);
    chk("reset_b", addr_bus, 16'h0000);

    // All DUT enables off: bench drives the buses and must read back its own value.
    n_oe_addr = 2'b11; n_oe_dl = 2'b11; n_oe_dh = 2'b11;
    tb_en = 1'b1; tb_addr = 16'hC3A5; tb_data = 8'h5A;
    #1;
    chk("hiz_addr", addr_bus, 16'hC3A5);
    chk("hiz_data", {8'h00, data_bus}, 16'h005A);
    tb_en = 1'b0;
    sel_addr(0);

    cyc(0, "wr_l34", 1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0);
    cyc(0, "wr_h12", 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0);
    chk("val_1234", addr_bus, 16'h1234);
    rd(0, "rd_lo", 1'b0, 1'b1, 8'h34);
    rd(0, "rd_hi", 1'b1, 1'b0, 8'h12);
    rd(0, "rd_both", 1'b0, 1'b0, 8'h34);

    load(1, 16'h00FF);
    cyc(1, "inc_carry", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("val_0100", addr_bus, 16'h0100);
    sel_addr(0);
    chk("swap_a", addr_bus, 16'h1234);

    load(0, 16'hFFFF);
    cyc(0, "wrap", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("val_0000", addr_bus, 16'h0000);

    load(0, 16'h1234);
    cyc(0, "wr_vs_cnt", 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    chk("val_12aa", addr_bus, 16'h12AA);

    load(0, 16'h5555);
    cyc(0, "rst_prio", 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, "cnt_after_rst", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    end
    chk("val_0003", addr_bus, 16'h0003);

    load(1, 16'hFFFE);
    for (int i = 0; i < 40; i++) begin
      int s;
      s = $urandom_range(0, 1);
      cyc(s, "rand", ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          8'($urandom_range(0, 255)), 1'b0);
      sel_addr(1 - s);
      chk("rand_swap", addr_bus, m[1 - s]);
    end

    if (exp_q.size() != 0) begin
      chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pointer_register.md
Name: pointer_register

Overview:
- 16-bit pointer register: one instruction-pointer or data-pointer register of the CPU datapath.
- Two instances share one 16-bit address bus and one 8-bit data bus inside the pointer-pair block. A selector decides which instance drives the address bus, which counts, and which is readable/writable on the data bus.
- All bus outputs are tri-state, so the two instances can be wired-OR'ed onto common nets.
- Supports byte-wise load from the data bus, byte-wise readback onto the data bus, and 16-bit increment.

Parameters:
- RESET_VALUE, 16'h0000, pointer value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes occur on the rising edge.
- rst  input  1  synchronous reset, active-high. The codebase marks active-low signals with an n_ prefix, so the active-high reset is named rst.
- di  input  8  data-bus byte to load.
- n_oe_addr  input  1  active-low address output enable.
- n_oe_dl  input  1  active-low enable for the low byte onto data_out.
- n_oe_dh  input  1  active-low enable for the high byte onto data_out.
- cnt  input  1  active-high increment enable.
- n_we_l  input  1  active-low low-byte write enable.
- n_we_h  input  1  active-low high-byte write enable.
- addr_out  output  16  pointer value, tri-state.
- data_out  output  8  selected pointer byte, tri-state.

Behaviour:
- State: 16-bit register ptr.
- Rising clk edge, priority order (highest first):
  1. rst=1: ptr <= RESET_VALUE. Overrides writes and cnt.
  2. Else, if n_we_l=0 or n_we_h=0: write cycle. n_we_l=0 loads ptr[7:0] <= di; n_we_h=0 loads ptr[15:8] <= di. Both low loads di into both bytes. A byte not written holds its value. cnt is ignored in a write cycle.
  3. Else, if cnt=1: ptr <= ptr + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000; carry propagates from low to high byte).
  4. Else: hold.
- addr_out = ptr when n_oe_addr=0, else 16'hZZZZ. Purely combinational, no latency; it reflects the register from the cycle after any update.
- data_out (combinational):
  - n_oe_dl=0: data_out = ptr[7:0]. Low byte wins if n_oe_dh is also 0.
  - n_oe_dl=1 and n_oe_dh=0: data_out = ptr[15:8].
  - Both 1: 8'hZZ.
- Output enables are independent of rst, cnt and writes. Outputs show the current registered value, including during reset assertion once the edge has occurred.
- Readback during a write cycle shows the old value until the edge.
- Reset asserted mid-count: the next edge yields RESET_VALUE. Counting resumes from there after rst deasserts.
- No X propagation from unused inputs: di is ignored unless a write is enabled.

Optional Feature:
- Macro POINTER_REG_CARRY_EN adds output port co (1 bit).
- co = cnt & (ptr == 16'hFFFF) & ~rst & n_we_l & n_we_h. Combinational, mirroring a 74x161 ripple-carry output. It marks the cycle whose increment wraps the pointer.
- Without the macro, the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for one edge, n_oe_addr=0 -> addr_out=16'h0000. All enables high -> addr_out=16'hZZZZ, data_out=8'hZZ.
- Byte write: di=8'h34 with n_we_l=0 for one edge, then di=8'h12 with n_we_h=0 for one edge. Result: addr_out=16'h1234; n_oe_dl=0 -> 8'h34; n_oe_dh=0 -> 8'h12; both low -> 8'h34.
- Count with carry: load 16'h00FF, cnt=1 for one edge -> 16'h0100. Load 16'hFFFF, cnt=1 -> 16'h0000; co=1 in the preceding cycle when the macro is defined.
- Write vs count: ptr=16'h1234, cnt=1, n_we_l=0, di=8'hAA -> 16'h12AA, with no increment.
- Reset priority: ptr=16'h5555, rst=1 with cnt=1 and n_we_h=0 -> 16'h0000. Deassert rst, cnt=1 for 3 edges -> 16'h0003.
- Shared bus: two instances on common nets with complementary n_oe_addr -> only the enabled value appears, never X. Swapping the enables swaps the value on the next delta.
